cpu_dmem_responder: RTL



---
 rtl/cpu_pkg.sv | 14 +
 rtl/dmem_array.sv | 33 +++
 rtl/cpu_dmem_responder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU data-bus widths, default memory depth and responder FSM encoding.
package cpu_pkg;

   localparam int CPU_DATA_W = 24;
   localparam int CPU_ADDR_W = 24;
   localparam int DMEM_DEPTH = 256;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W data store: synchronous write, synchronous read into a clearable response register.
// rdata updates one edge after rd_en/rd_clr; no backpressure of its own.
module dmem_array
   import cpu_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_W,
   parameter int DEPTH  = DMEM_DEPTH,
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic              rd_clr,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage is deliberately left out of reset so contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (wr_en) mem[idx] <= wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        rdata <= '0;
      else if (rd_en)  rdata <= mem[idx];
      else if (rd_clr) rdata <= '0;
   end

endmodule

// File: rtl/cpu_dmem_responder.sv
// CPU data-bus memory responder: one outstanding load/store, response WAIT_STATES+1 cycles after accept.
// Response outputs hold while rsp_ready is low; no new request is taken until the response is consumed.
module cpu_dmem_responder
   import cpu_pkg::*;
#(
   parameter int DATA_W      = CPU_DATA_W,
   parameter int ADDR_W      = CPU_ADDR_W,
   parameter int DEPTH       = DMEM_DEPTH,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]      CNT_LOAD  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
   localparam logic [ADDR_W:0] CMP_DEPTH = (ADDR_W + 1)'(DEPTH);

   state_t              state, state_nxt;
   logic [3:0]          cnt;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                accept, enter_resp, consume;
   logic                op_we, op_in_range;
   logic [ADDR_W-1:0]   op_addr;
   logic [DATA_W-1:0]   op_wdata;
   logic                mem_wr, mem_rd, mem_clr;

   // With zero wait states RESP is entered on the accept edge, so use the live request there.
   assign op_we       = (state == ST_IDLE) ? req_we    : we_q;
   assign op_addr     = (state == ST_IDLE) ? req_addr  : addr_q;
   assign op_wdata    = (state == ST_IDLE) ? req_wdata : wdata_q;
   assign op_in_range = ({1'b0, op_addr} < CMP_DEPTH);

   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      accept     = 1'b0;
      enter_resp = 1'b0;
      consume    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            req_ready = rst;
            if (req_valid && rst) begin
               accept = 1'b1;
               if (WAIT_STATES == 0) begin
                  state_nxt  = ST_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt == 4'd0) begin
               state_nxt  = ST_RESP;
               enter_resp = 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_nxt = ST_IDLE;
               consume   = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         cnt       <= 4'd0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= CNT_LOAD;
         end else if (state == ST_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (enter_resp) begin
            rsp_valid <= 1'b1;
            rsp_err   <= !op_in_range;
         end else if (consume) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
         end
      end
   end

   assign mem_wr  = enter_resp && op_we && op_in_range;
   assign mem_rd  = enter_resp && !op_we && op_in_range;
   assign mem_clr = (enter_resp && !mem_rd) || consume;

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_dmem (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (mem_wr),
      .rd_en  (mem_rd),
      .rd_clr (mem_clr),
      .idx    (op_addr[IDX_W-1:0]),
      .wdata  (op_wdata),
      .rdata  (rsp_rdata)
   );

endmodule
